wb_spi_sram_ctrl: RTL and testbench

- Wishbone-to-SPI bridge between the SERV SoC data/instruction bus and an external 23LC512 serial SRAM.
- Sits directly upstream of the SRAM: drives spi_clk/spi_mosi/spi_cs1 and samples spi_miso.
- Converts each single Wishbone classic access into one SPI mode-0 sequential-mode READ (0x03) or WRITE (0x02) transaction with a 16-bit address.
- Holds the ack until the transaction completes.

---
 rtl/wb_spi_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_wb_spi_sram_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_sram_ctrl.sv
// Wishbone classic slave that turns each access into one 23LC512 SPI mode-0
// sequential READ/WRITE transaction. The ack is held off until the frame has been shifted out.
module wb_spi_sram_ctrl #(
  parameter int AW      = 16,
  parameter int CLK_DIV = 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_spi_clk,
  output logic          o_spi_mosi,
  input  logic          i_spi_miso,
  output logic          o_spi_cs_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e        state_q;
  logic [DW-1:0] divCnt_q;
  logic [5:0]    bitCnt_q;
  logic [5:0]    lastBit_q;
  logic [55:0]   frame_q;
  logic [31:0]   rx_q;
  logic          we_q;
  logic          sck_q;
  logic          csn_q;
  logic          mosi_q;
  logic          ack_q;
  logic [31:0]   rdt_q;

  logic [15:0]   adr16;
  logic [1:0]    lo;
  logic [1:0]    hi;
  logic [2:0]    spanBytes;
  logic [31:0]   byteSeq;
  logic [31:0]   payload;
  logic [55:0]   frameD;
  logic [5:0]    lastBitD;
  logic          sampleNow;
  logic [31:0]   rxD;
  logic          phaseEnd;
  logic          unusedBits;

  assign adr16      = 16'(i_wb_adr);
  assign unusedBits = ^adr16[1:0];

  always_comb begin
    lo = 2'd0;
    hi = 2'd0;
    for (int i = 3; i >= 0; i--) if (i_wb_sel[i]) lo = 2'(i);
    for (int i = 0; i < 4; i++)  if (i_wb_sel[i]) hi = 2'(i);
  end

  // Bytes are sent in address order, so lane 0 leads; shifting by lo drops
  // the unselected low lanes and left-aligns the span.
  assign byteSeq   = {i_wb_dat[7:0], i_wb_dat[15:8], i_wb_dat[23:16], i_wb_dat[31:24]};
  assign payload   = byteSeq << {lo, 3'b000};
  assign spanBytes = 3'({1'b0, hi} - {1'b0, lo}) + 3'd1;
  assign frameD    = i_wb_we ? {8'h02, adr16[15:2], lo, payload}
                             : {8'h03, adr16[15:2], 2'b00, 32'h0};
  assign lastBitD  = i_wb_we ? (6'd23 + {spanBytes, 3'b000}) : 6'd55;

  assign phaseEnd  = (divCnt_q == DIV_LAST);
  assign sampleNow = (state_q == SHIFT) && sck_q && (divCnt_q == '0);
  assign rxD       = sampleNow ? {rx_q[30:0], i_spi_miso} : rx_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      lastBit_q <= '0;
      frame_q   <= '0;
      rx_q      <= '0;
      we_q      <= 1'b0;
      sck_q     <= 1'b0;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
    end else begin
      rx_q <= rxD;
      case (state_q)
        IDLE: begin
          if (i_wb_cyc) begin
            we_q     <= i_wb_we;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            if (i_wb_we && (i_wb_sel == 4'b0000)) begin
              ack_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              csn_q     <= 1'b0;
              sck_q     <= 1'b0;
              mosi_q    <= frameD[55];
              frame_q   <= {frameD[54:0], 1'b0};
              lastBit_q <= lastBitD;
              state_q   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (phaseEnd) begin
            divCnt_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else if (bitCnt_q == lastBit_q) begin
              sck_q   <= 1'b0;
              csn_q   <= 1'b1;
              mosi_q  <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= DONE;
              // The final sample may land on this very edge, hence rxD
              if (!we_q) rdt_q <= {rxD[7:0], rxD[15:8], rxD[23:16], rxD[31:24]};
            end else begin
              sck_q    <= 1'b0;
              mosi_q   <= frame_q[55];
              frame_q  <= {frame_q[54:0], 1'b0};
              bitCnt_q <= bitCnt_q + 6'd1;
            end
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        DONE: begin
          ack_q    <= 1'b0;
          divCnt_q <= '0;
          state_q  <= GAP;
        end
        GAP: begin
          if (phaseEnd) state_q <= IDLE;
          else          divCnt_q <= divCnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_rdt   = rdt_q;
  assign o_wb_ack   = ack_q;
  assign o_spi_clk  = sck_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_cs_n = csn_q;

endmodule

// File: tb/tb_wb_spi_sram_ctrl.sv
// Bench for wb_spi_sram_ctrl: two instances (CLK_DIV=1 and 3) share a behavioural
// 23LC512 model; expected acks, read data and MOSI bytes come from a scoreboard.
module tb_wb_spi_sram_ctrl;

  typedef struct {
    int          ackCycle;
    logic [31:0] rdt;
  } exp_t;

  logic        clock = 1'b0;
  logic        rstN  = 1'b1;
  logic [15:0] wbAdr = '0;
  logic [31:0] wbDat = '0;
  logic [3:0]  wbSel = '0;
  logic        wbWe  = 1'b0;
  logic        cyc1  = 1'b0;
  logic        cyc3  = 1'b0;
  logic [31:0] rdt1, rdt3;
  logic        ack1, ack3, sck1, sck3, mosi1, mosi3, csn1, csn3;
  logic        miso  = 1'b0;

  logic        spiClk, spiMosi, spiCsn;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  refMem [0:65535];
  logic [7:0]  expBytes[$];
  logic [7:0]  gotBytes[$];
  exp_t        expQ[$];
  logic [31:0] lastRdt1 = '0;
  logic [31:0] lastRdt3 = '0;

  int          checkCount = 0;
  int          errorCount = 0;

  int          sBit = 0;
  logic [7:0]  sCmd = '0;
  logic [15:0] sAddr = '0;
  logic [7:0]  sShift = '0;

  always #5 clock = ~clock;

  wb_spi_sram_ctrl #(.AW(16), .CLK_DIV(1)) dut1 (
    .wb_clk(clock), .wb_rst_n(rstN), .i_wb_adr(wbAdr), .i_wb_dat(wbDat),
    .i_wb_sel(wbSel), .i_wb_we(wbWe), .i_wb_cyc(cyc1), .o_wb_rdt(rdt1),
    .o_wb_ack(ack1), .o_spi_clk(sck1), .o_spi_mosi(mosi1), .i_spi_miso(miso),
    .o_spi_cs_n(csn1)
  );

  wb_spi_sram_ctrl #(.AW(16), .CLK_DIV(3)) dut3 (
    .wb_clk(clock), .wb_rst_n(rstN), .i_wb_adr(wbAdr), .i_wb_dat(wbDat),
    .i_wb_sel(wbSel), .i_wb_we(wbWe), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3),
    .o_wb_ack(ack3), .o_spi_clk(sck3), .o_spi_mosi(mosi3), .i_spi_miso(miso),
    .o_spi_cs_n(csn3)
  );

  // Only one controller is ever selected, so the SRAM sees whichever is active
  assign spiCsn  = csn1 & csn3;
  assign spiClk  = csn1 ? sck3 : sck1;
  assign spiMosi = csn1 ? mosi3 : mosi1;

  always @(negedge spiCsn) begin
    sBit = 0;
    miso = 1'b0;
  end

  always @(posedge spiClk) begin
    if (!spiCsn) begin
      if (sBit < 8) begin
        sCmd = {sCmd[6:0], spiMosi};
        if (sBit == 7) gotBytes.push_back(sCmd);
      end else if (sBit < 24) begin
        sAddr = {sAddr[14:0], spiMosi};
        if (sBit == 15) gotBytes.push_back(sAddr[7:0]);
        if (sBit == 23) gotBytes.push_back(sAddr[7:0]);
      end else if (sCmd == 8'h02) begin
        sShift = {sShift[6:0], spiMosi};
        if (((sBit - 24) % 8) == 7) begin
          gotBytes.push_back(sShift);
          mem[sAddr] = sShift;
          sAddr = sAddr + 16'd1;
        end
      end
      sBit++;
    end
  end

  always @(negedge spiClk) begin
    if (!spiCsn && sBit >= 24 && sCmd == 8'h03) begin
      logic [7:0] rdByte;
      rdByte = mem[sAddr + 16'((sBit - 24) / 8)];
      miso = rdByte[7 - ((sBit - 24) % 8)];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One Wishbone access on the chosen instance; cycle 0 is the cycle cyc is first seen
  task automatic applyStimulus(input int div, input bit we, input logic [15:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    exp_t        e;
    int          lo, hi, nBits, ackAt, csFirst, csLast, rise0, rise1, extra;
    logic        prevSck, curSck, curCsn, curAck;
    logic [31:0] curRdt, ackRdt;
    logic [15:0] base;
    lo = 0; hi = -1;
    for (int i = 0; i < 4; i++) if (sel[i]) begin
      if (hi < 0) lo = i;
      hi = i;
    end
    base = {adr[15:2], 2'b00};
    expBytes.delete();
    gotBytes.delete();
    if (we && sel == 4'b0000) begin
      nBits = 0;
    end else begin
      expBytes.push_back(we ? 8'h02 : 8'h03);
      expBytes.push_back(adr[15:8]);
      expBytes.push_back(we ? {adr[7:2], 2'(lo)} : {adr[7:2], 2'b00});
      if (we) begin
        for (int b = lo; b <= hi; b++) begin
          expBytes.push_back(dat[8*b +: 8]);
          refMem[base + 16'(b)] = dat[8*b +: 8];
        end
      end
      nBits = we ? 24 + 8 * (hi - lo + 1) : 56;
    end
    if (!we) begin
      if (div == 3) lastRdt3 = {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
      else          lastRdt1 = {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
    end
    e.ackCycle = (nBits == 0) ? 1 : 2 * div * nBits + 1;
    e.rdt      = (div == 3) ? lastRdt3 : lastRdt1;
    expQ.push_back(e);

    @(negedge clock);
    wbAdr = adr; wbDat = dat; wbSel = sel; wbWe = we;
    if (div == 3) cyc3 = 1'b1; else cyc1 = 1'b1;
    ackAt = 0; csFirst = 0; csLast = 0; rise0 = 0; rise1 = 0; prevSck = 1'b0; ackRdt = '0;
    for (int c = 1; c <= 2 * div * 56 + 20; c++) begin
      @(negedge clock);
      curSck = (div == 3) ? sck3 : sck1;
      curCsn = (div == 3) ? csn3 : csn1;
      curAck = (div == 3) ? ack3 : ack1;
      curRdt = (div == 3) ? rdt3 : rdt1;
      if (!curCsn) begin
        if (csFirst == 0) csFirst = c;
        csLast = c;
      end
      if (curSck && !prevSck) begin
        if (rise0 == 0) rise0 = c;
        else if (rise1 == 0) rise1 = c;
      end
      prevSck = curSck;
      if (curAck) begin
        ackAt = c;
        ackRdt = curRdt;
        cyc1 = 1'b0; cyc3 = 1'b0;
        break;
      end
    end
    cyc1 = 1'b0; cyc3 = 1'b0;
    e = expQ.pop_front();
    checkOutput("ackCycle", ackAt, e.ackCycle);
    checkOutput("rdt", ackRdt, e.rdt);
    if (nBits != 0) begin
      checkOutput("csFirstLow", csFirst, 1);
      checkOutput("csLastLow", csLast, e.ackCycle - 1);
      checkOutput("sckPeriod", rise1 - rise0, 2 * div);
      checkOutput("mosiByteCount", gotBytes.size(), expBytes.size());
      for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++)
        checkOutput($sformatf("mosiByte%0d", i), gotBytes[i], expBytes[i]);
    end else begin
      checkOutput("csNeverLow", csFirst, 0);
    end
    extra = 0;
    for (int c = 0; c < 2 * div + 4; c++) begin
      @(negedge clock);
      if ((div == 3) ? ack3 : ack1) extra++;
    end
    checkOutput("noExtraAck", extra, 0);
  endtask

  initial begin
    int   edges, n, ackAt;
    logic prev1, prev3;
    exp_t e;

    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      refMem[i] = 8'(i) ^ 8'h5A;
    end

    #2 rstN = 1'b0;
    #1;
    checkOutput("rstCsn", csn1, 1);
    checkOutput("rstSck", sck1, 0);
    checkOutput("rstMosi", mosi1, 0);
    checkOutput("rstAck", ack1, 0);
    checkOutput("rstRdt", rdt1, 0);
    checkOutput("rstCsn3", csn3, 1);
    repeat (3) @(negedge clock);
    rstN = 1'b1;

    edges = 0; prev1 = sck1; prev3 = sck3;
    repeat (20) begin
      @(negedge clock);
      if (sck1 != prev1) edges++;
      if (sck3 != prev3) edges++;
      prev1 = sck1; prev3 = sck3;
    end
    checkOutput("idleSckEdges", edges, 0);

    applyStimulus(1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111);
    applyStimulus(1, 1'b0, 16'h0010, 32'h0, 4'b0000);
    applyStimulus(1, 1'b1, 16'h0020, 32'h00AA0000, 4'b0100);
    applyStimulus(1, 1'b0, 16'h0020, 32'h0, 4'b0000);
    applyStimulus(1, 1'b1, 16'h0040, 32'h12345678, 4'b0000);
    applyStimulus(1, 1'b1, 16'h0030, 32'h11223344, 4'b1001);
    applyStimulus(1, 1'b0, 16'h0030, 32'h0, 4'b0000);

    // Abort a read with reset at cycle 40
    @(negedge clock);
    wbAdr = 16'h0010; wbWe = 1'b0; wbSel = 4'b0000; cyc1 = 1'b1;
    repeat (40) @(negedge clock);
    rstN = 1'b0;
    #1;
    checkOutput("abortCsn", csn1, 1);
    checkOutput("abortSck", sck1, 0);
    checkOutput("abortRdt", rdt1, 0);
    lastRdt1 = '0;
    cyc1 = 1'b0;
    @(negedge clock);
    rstN = 1'b1;
    n = 0;
    repeat (120) begin
      @(negedge clock);
      if (ack1) n++;
    end
    checkOutput("abortNoAck", n, 0);
    applyStimulus(1, 1'b0, 16'h0010, 32'h0, 4'b0000);

    applyStimulus(3, 1'b0, 16'h0010, 32'h0, 4'b0000);

    // Back-to-back reads with cyc held: DONE, 3 GAP cycles and the IDLE cycle keep CS high
    e.ackCycle = 337;
    e.rdt      = {refMem[16'h13], refMem[16'h12], refMem[16'h11], refMem[16'h10]};
    expQ.push_back(e);
    expQ.push_back(e);
    @(negedge clock);
    wbAdr = 16'h0010; wbWe = 1'b0; cyc3 = 1'b1;
    ackAt = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clock);
      if (ack3) begin ackAt = c; break; end
    end
    e = expQ.pop_front();
    checkOutput("gapAckCycle", ackAt, e.ackCycle);
    checkOutput("gapRdt", rdt3, e.rdt);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (!csn3) begin n = c; break; end
    end
    checkOutput("gapCsHighCycles", n, 5);
    ackAt = 0;
    for (int c = 1; c <= 400; c++) begin
      if (ack3) begin ackAt = c; break; end
      @(negedge clock);
    end
    cyc3 = 1'b0;
    e = expQ.pop_front();
    checkOutput("gap2AckCycle", ackAt, e.ackCycle);
    checkOutput("gap2Rdt", rdt3, e.rdt);
    repeat (10) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
